vga_scan_ctrl: RTL
==================

Name: vga_scan_ctrl

Overview:
- Raster timing generator and pixel output stage for the display path.
- Produces the pixel coordinates that drive the renderer's iCoord_X / iCoord_Y inputs.
- Takes the renderer's RGB back, realigns HSYNC/VSYNC/BLANK to the renderer's pipeline latency, and drives the VGA DAC.
- Emits a once-per-frame tick for the game-logic timebase.

Parameters:
- CLK_DIV, 2, system clocks per pixel (1..4); pixel-enable divider.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, pixels.
- H_SYNC, 96, hsync width, pixels.
- H_BP, 48, horizontal back porch, pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, lines.
- V_SYNC, 2, vsync width, lines.
- V_BP, 33, vertical back porch, lines.
- SYNC_POL, 0, asserted sync level (0 = active-low).
- PIPE_LAT, 2, renderer latency in clk cycles from coordinate change to valid RGB (0..7).

Ports:
- clk  in  1  system clock; the only clock.
- iRST  in  1  reset, synchronous, active-high.
- iRed  in  8  renderer red for coordinates issued PIPE_LAT cycles earlier.
- iGreen  in  8  renderer green, same alignment as iRed.
- iBlue  in  8  renderer blue, same alignment as iRed.
- oCoord_X  out  13  horizontal counter, 0..H_TOTAL-1.
- oCoord_Y  out  11  vertical counter, 0..V_TOTAL-1.
- oPix_en  out  1  one-clk pulse when the counters advance.
- oFrame_tick  out  1  one-clk pulse at the start of vertical blank.
- oVGA_R  out  8  registered red to DAC.
- oVGA_G  out  8  registered green to DAC.
- oVGA_B  out  8  registered blue to DAC.
- oVGA_HS  out  1  hsync, latency-aligned.
- oVGA_VS  out  1  vsync, latency-aligned.
- oVGA_BLANK_N  out  1  high during active video, latency-aligned.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt == CLK_DIV-1). With CLK_DIV=1, pix_en is constantly 1.
- On pix_en:
  - h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 on the same pix_en as h_cnt's wrap.
  - oCoord_X = h_cnt and oCoord_Y = v_cnt, driven directly from the registers. They are stable for CLK_DIV clocks.
- Line layout: active [0, H_ACTIVE), then front porch, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then back porch. Vertical uses the same layout in lines.
- Raw, undelayed timing signals:
  - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_raw asserted when h_cnt is in the hsync window.
  - vs_raw asserted when v_cnt is in the vsync window; it changes only at a line wrap.
- Alignment: act, hs_raw and vs_raw pass through a shift register of PIPE_LAT stages clocked every clk, then one output register stage.
- RGB output register: captures iRed/iGreen/iBlue every clk. It loads 0 when the delayed act is 0.
- Net latency: coordinate change to the DAC pins is PIPE_LAT+1 clks for every output.
- oFrame_tick: registered pulse, high for exactly one clk. It fires on the clk after the pix_en at which (h_cnt, v_cnt) becomes (0, V_ACTIVE). Exactly one pulse per frame. It is not latency-aligned.
- oPix_en: registered copy of pix_en, coincident with the coordinate update.
- Reset, when iRST is sampled high, including mid-frame:
  - div_cnt, h_cnt, v_cnt = 0.
  - Every delay-line stage: act = 0, hs/vs = deasserted.
  - oVGA_R/G/B = 0; oVGA_HS = oVGA_VS = ~SYNC_POL; oVGA_BLANK_N = 0.
  - oFrame_tick = 0; oPix_en = 0.
  - The first pix_en after reset is the clk where div_cnt reaches CLK_DIV-1.
- Width rules: counters are sized to the output widths. Parameter legality (H_TOTAL < 8192, V_TOTAL < 2048, CLK_DIV 1..4) is an elaboration-time check.

Decomposition:
- Shared package vga_timing_pkg:
  - default timing constants for 640x480@60;
  - derived H_TOTAL, V_TOTAL and sync window start/end localparams;
  - typedef for the aligned timing bundle {act, hs, vs}.
- One sub-module: vga_delay_line, a parameterised-depth shift register carrying the timing bundle. It is reused by any future renderer stage with a different latency.

Test Plan:
- Reset then release, CLK_DIV=2: coordinates (0,0). RGB=0, HS=VS=1, BLANK_N=0 for PIPE_LAT+1 clks. First coordinate step to X=1 occurs 2 clks after release.
- Run one line: X sequence 0..799 then 0, Y increments once. HS low for exactly 192 clks, starting 1312+PIPE_LAT+1 clks after X=0.
- Run one frame: VS low for exactly 2 lines (3200 clks). oFrame_tick pulses once, at coordinate (0,480). Tick period is exactly 840000 clks.
- Latency check with PIPE_LAT=2: bench model returns iRed=X[7:0] delayed 2 clks. oVGA_R equals the X of the pixel whose BLANK_N is high, and is 0 for all blanked pixels.
- Assert iRST for 1 clk at (X=400, Y=200): next clk all outputs at reset values. Counting restarts from (0,0). No spurious oFrame_tick.
- CLK_DIV=1: oPix_en is constantly 1 outside reset. Line period is 800 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA display path.
// Holds 640x480@60 defaults, the derived totals and sync windows, and the timing bundle type.
// Contains no logic. The window helper is purely combinational.
package vga_timing_pkg;

  // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Derived totals and sync windows for the default mode
  localparam int DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START   = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START   = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

  // Timing bundle carried alongside the renderer pipeline; hs/vs are logical "asserted" flags
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } vga_timing_t;

  // Half-open window test: lo <= cnt < hi
  function automatic logic in_window(logic [15:0] cnt, logic [15:0] lo, logic [15:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Shift register that delays the raster timing bundle to match a renderer's pipeline depth.
// Latency is DEPTH clk cycles; DEPTH=0 is a plain wire.
// No backpressure: every stage advances on every clk, and reset clears all stages to idle.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  vga_timing_t dat_i,
  output vga_timing_t dat_o
);

  if (DEPTH == 0) begin : g_bypass
    assign dat_o = dat_i;
  end else begin : g_stages
    vga_timing_t stage_q [DEPTH];

    // Advance the bundle one stage per clk; reset to inactive / sync deasserted
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= dat_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dat_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan generator: pixel coordinates out, renderer RGB back in, aligned sync/blank to the DAC.
// Coordinates update on pix_en; DAC outputs trail the coordinates by PIPE_LAT+1 clks.
// No backpressure: the raster free-runs, and the renderer must meet PIPE_LAT exactly.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        iRST,
  input  logic [7:0]  iRed,
  input  logic [7:0]  iGreen,
  input  logic [7:0]  iBlue,
  output logic [12:0] oCoord_X,
  output logic [10:0] oCoord_Y,
  output logic        oPix_en,
  output logic        oFrame_tick,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [1:0]  DIV_LAST = 2'(CLK_DIV - 1);
  localparam logic [12:0] H_LAST   = 13'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);

  if (H_TOTAL >= 8192 || V_TOTAL >= 2048 || CLK_DIV < 1 || CLK_DIV > 4 ||
      PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_param_check
    $error("vga_scan_ctrl: illegal timing parameters");
  end

  logic [1:0]  div_cnt_q;
  logic [12:0] h_cnt_q;
  logic [10:0] v_cnt_q;
  logic        pix_en;
  logic        pix_en_q;
  logic        frame_tick_q;
  vga_timing_t timing_raw;
  vga_timing_t timing_dly;
  logic [7:0]  red_q, green_q, blue_q;
  logic        hs_q, vs_q, blank_n_q;

  assign pix_en = (div_cnt_q == DIV_LAST);

  // Pixel-enable divider: counts 0..CLK_DIV-1 and wraps
  always_ff @(posedge clk) begin
    if (iRST || pix_en) div_cnt_q <= '0;
    else                div_cnt_q <= div_cnt_q + 2'd1;
  end

  // Raster counters: h wraps at end of line, v steps on that wrap and wraps at end of frame
  always_ff @(posedge clk) begin
    if (iRST) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_q <= '0;
        v_cnt_q <= (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_q <= h_cnt_q + 13'd1;
      end
    end
  end

  // Strobes coincident with the coordinate update; the tick marks entry to vertical blank
  always_ff @(posedge clk) begin
    if (iRST) begin
      pix_en_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pix_en_q     <= pix_en;
      frame_tick_q <= pix_en && (h_cnt_q == H_LAST) && (v_cnt_q == V_ACT_LAST);
    end
  end

  // Undelayed timing decoded from the current coordinates
  always_comb begin
    timing_raw     = '0;
    timing_raw.act = (h_cnt_q < 13'(H_ACTIVE)) && (v_cnt_q < 11'(V_ACTIVE));
    timing_raw.hs  = in_window(16'(h_cnt_q), 16'(HS_START), 16'(HS_END));
    timing_raw.vs  = in_window(16'(v_cnt_q), 16'(VS_START), 16'(VS_END));
  end

  vga_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_timing_dly (
    .clk_i (clk),
    .rst_i (iRST),
    .dat_i (timing_raw),
    .dat_o (timing_dly)
  );

  // DAC output stage: RGB forced to black outside active video, sync driven at the chosen polarity
  always_ff @(posedge clk) begin
    if (iRST) begin
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      blank_n_q <= 1'b0;
    end else begin
      red_q     <= timing_dly.act ? iRed   : 8'd0;
      green_q   <= timing_dly.act ? iGreen : 8'd0;
      blue_q    <= timing_dly.act ? iBlue  : 8'd0;
      hs_q      <= timing_dly.hs ? SYNC_POL : ~SYNC_POL;
      vs_q      <= timing_dly.vs ? SYNC_POL : ~SYNC_POL;
      blank_n_q <= timing_dly.act;
    end
  end

  assign oCoord_X     = h_cnt_q;
  assign oCoord_Y     = v_cnt_q;
  assign oPix_en      = pix_en_q;
  assign oFrame_tick  = frame_tick_q;
  assign oVGA_R       = red_q;
  assign oVGA_G       = green_q;
  assign oVGA_B       = blue_q;
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_N = blank_n_q;

endmodule
